uart_tx_arbiter: RTL and testbench
==================================

UART_TX_ARBITER -- requirements
Module: uart_tx_arbiter

Interface
REQ-001 Parameter TIMEOUT_CYC, default 1023: owner-idle cycles before a locked grant is forcibly released.
REQ-002 clk  in  1  system clock; all logic is on the rising edge.
REQ-003 rst_n  in  1  asynchronous active-low reset.
REQ-004 req_valid  in  3  per-requester byte available; bit0 = echo, bit1 = result display, bit2 = error message.
REQ-005 req_data0/req_data1/req_data2  in  8 each  byte offered by each requester.
REQ-006 req_last  in  3  per-requester flag: the offered byte ends its packet.
REQ-007 req_ready  out  3  one-cycle pulse: the offered byte was accepted.
REQ-008 tx_data  out  8  byte to uart_tx.
REQ-009 tx_start  out  1  one-cycle start pulse to uart_tx.
REQ-010 tx_busy  in  1  uart_tx is serialising a byte.
REQ-011 grant  out  3  one-hot current owner; 0 when idle.
REQ-012 drop  out  1  one-cycle pulse when a grant is released by timeout.

Function
REQ-013 States are IDLE, LOCK, ISSUE, WAIT_HI and WAIT_LO.
- Transitions from IDLE: to LOCK when any req_valid is set.
- Transitions from LOCK: to ISSUE when req_valid[owner] is set and tx_busy is 0.
- Transitions from ISSUE: to WAIT_HI unconditionally.
- Transitions from WAIT_HI: to WAIT_LO when tx_busy is 1.
- Transitions from WAIT_LO: when tx_busy is 0, to IDLE if the latched last flag is set, otherwise to LOCK.
REQ-014 In IDLE the block picks the owner round-robin, starting from the index after the most recently released owner (pointer reset value = 2, so bit0 wins first), and registers it into grant on entry to LOCK.
REQ-015 In ISSUE:
- tx_start = 1;
- tx_data = req_dataN of the owner, registered;
- req_ready[owner] = 1;
- req_last[owner] is latched.
All three outputs are valid in the same cycle.
REQ-016 Latency is 2 cycles from req_valid rising in IDLE (with tx_busy = 0) to tx_start.
REQ-017 Only the owner receives req_ready; other req_valid inputs are ignored until the owner releases in IDLE, so packets are never interleaved.
REQ-018 grant remains set from LOCK through WAIT_LO of the last byte, and clears on the cycle IDLE is entered.
REQ-019 The round-robin pointer updates to the owner index on every release, whether by last byte or by timeout.
REQ-020 In LOCK, a counter increments every cycle req_valid[owner] is 0 and clears when it is 1.
- When the counter reaches TIMEOUT_CYC, the block pulses drop, clears grant and goes to IDLE.
- The counter does not run in ISSUE, WAIT_HI or WAIT_LO.
REQ-021 tx_busy already high while in LOCK only delays ISSUE; it does not advance the timeout counter.
REQ-022 Simultaneous req_valid in IDLE: exactly one owner is granted, and the losers retain their byte (no req_ready).
REQ-023 At most one tx_start is issued per WAIT_LO->LOCK/IDLE cycle; no byte is ever issued while tx_busy = 1.

Reset
REQ-024 Reset values:
- state = IDLE;
- grant, req_ready, tx_start, drop = 0;
- tx_data = 0x00;
- round-robin pointer = 2;
- timeout counter and latched last = 0.
REQ-025 Reset asserted mid-packet returns the block to IDLE asynchronously. Any partially sent packet is abandoned without a drop pulse.

Structure
REQ-026 A shared package holds:
- the state encoding (3 bits);
- requester index constants REQ_ECHO = 0, REQ_DISP = 1, REQ_ERR = 2;
- the TIMEOUT_CYC default;
- the counter width (10 bits).
REQ-027 The round-robin picker is a combinational sub-module, uart_rr_pick. It takes req_valid and the pointer, and returns a one-hot winner.

Verification
REQ-028 Single-byte packet: req_valid = 001, req_data0 = 0x41, req_last = 001, tx_busy model 10 cycles. Required: tx_start 2 cycles later with tx_data = 0x41, req_ready = 001, grant = 001 until tx_busy falls, then 000.
REQ-029 Contention: req_valid = 111 from reset, each requester sending a 2-byte packet. Required: packets output in order bit0, bit1, bit2, with no interleaving; next round starts at bit0 again.
REQ-030 Lock hold: owner bit1 sends 3 bytes (0x31, 0x32, 0x33; last on the third) while bit2 holds req_valid high. Required: bit2 receives no req_ready until after 0x33 completes, and tx_data sequence = 31, 32, 33, then bit2's byte.
REQ-031 Timeout: owner bit0 sends one non-last byte, then drops req_valid. Required: drop pulses exactly TIMEOUT_CYC cycles after LOCK re-entry, grant = 000, and pending bit1 is granted next.
REQ-032 Busy entry and mid-packet reset:
- tx_busy held high when a request arrives: tx_start waits until tx_busy = 0.
- rst_n asserted in WAIT_LO: all outputs reach reset values immediately.
- After reset release, bit0 wins first.

Source files
------------

// File: rtl/uart_tx_arbiter_pkg.sv
// Shared types and constants for the UART transmit arbiter: state encoding,
// requester indices and timeout counter sizing.
package uart_tx_arbiter_pkg;

    localparam int unsigned NUM_REQ         = 3;
    localparam int unsigned TIMEOUT_CYC_DEF = 1023;
    localparam int unsigned CNT_W           = 10;

    localparam int unsigned REQ_ECHO = 0;
    localparam int unsigned REQ_DISP = 1;
    localparam int unsigned REQ_ERR  = 2;

    typedef enum logic [2:0] {
        StIdle   = 3'd0,
        StLock   = 3'd1,
        StIssue  = 3'd2,
        StWaitHi = 3'd3,
        StWaitLo = 3'd4
    } state_e;

    function automatic logic [1:0] onehot_to_idx(input logic [NUM_REQ-1:0] oh);
        return oh[REQ_ERR] ? 2'd2 : (oh[REQ_DISP] ? 2'd1 : 2'd0);
    endfunction

endpackage

// File: rtl/uart_rr_pick.sv
// Combinational round-robin picker: the search starts at the requester after
// i_ptr (the last released owner) and returns a one-hot winner.
module uart_rr_pick
    import uart_tx_arbiter_pkg::*;
(
    input  logic [NUM_REQ-1:0] i_valid,
    input  logic [1:0]         i_ptr,
    output logic [NUM_REQ-1:0] o_win
);

    always_comb begin
        o_win = '0;
        case (i_ptr)
            2'd0: begin
                if      (i_valid[REQ_DISP]) o_win = 3'b010;
                else if (i_valid[REQ_ERR])  o_win = 3'b100;
                else if (i_valid[REQ_ECHO]) o_win = 3'b001;
            end
            2'd1: begin
                if      (i_valid[REQ_ERR])  o_win = 3'b100;
                else if (i_valid[REQ_ECHO]) o_win = 3'b001;
                else if (i_valid[REQ_DISP]) o_win = 3'b010;
            end
            default: begin
                if      (i_valid[REQ_ECHO]) o_win = 3'b001;
                else if (i_valid[REQ_DISP]) o_win = 3'b010;
                else if (i_valid[REQ_ERR])  o_win = 3'b100;
            end
        endcase
    end

endmodule

// File: rtl/uart_tx_arbiter.sv
// Packet-locking arbiter feeding three byte producers into one uart_tx; an owner
// keeps the link until its last byte, or until it stalls for TIMEOUT_CYC cycles.
module uart_tx_arbiter
    import uart_tx_arbiter_pkg::*;
#(
    parameter int unsigned TIMEOUT_CYC = TIMEOUT_CYC_DEF
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic [NUM_REQ-1:0] req_valid,
    input  logic [7:0]         req_data0,
    input  logic [7:0]         req_data1,
    input  logic [7:0]         req_data2,
    input  logic [NUM_REQ-1:0] req_last,
    output logic [NUM_REQ-1:0] req_ready,
    output logic [7:0]         tx_data,
    output logic               tx_start,
    input  logic               tx_busy,
    output logic [NUM_REQ-1:0] grant,
    output logic               drop
);

    localparam logic [CNT_W-1:0] TO_LAST = CNT_W'(TIMEOUT_CYC - 1);

    state_e             r_state;
    logic [NUM_REQ-1:0] r_grant;
    logic [NUM_REQ-1:0] r_req_ready;
    logic [7:0]         r_tx_data;
    logic               r_tx_start;
    logic               r_drop;
    logic               r_last;
    logic [1:0]         r_ptr;
    logic [CNT_W-1:0]   r_cnt;

    logic [NUM_REQ-1:0] w_win;
    logic [1:0]         w_owner_idx;
    logic               w_owner_valid;
    logic               w_owner_last;
    logic [7:0]         w_owner_data;

    uart_rr_pick u_pick (
        .i_valid (req_valid),
        .i_ptr   (r_ptr),
        .o_win   (w_win)
    );

    assign w_owner_idx   = onehot_to_idx(r_grant);
    assign w_owner_valid = |(req_valid & r_grant);
    assign w_owner_last  = |(req_last & r_grant);
    assign w_owner_data  = ({8{r_grant[REQ_ECHO]}} & req_data0)
                         | ({8{r_grant[REQ_DISP]}} & req_data1)
                         | ({8{r_grant[REQ_ERR]}}  & req_data2);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= StIdle;
            r_grant     <= '0;
            r_req_ready <= '0;
            r_tx_data   <= 8'h00;
            r_tx_start  <= 1'b0;
            r_drop      <= 1'b0;
            r_last      <= 1'b0;
            r_ptr       <= 2'd2;
            r_cnt       <= '0;
        end else begin
            r_tx_start  <= 1'b0;
            r_req_ready <= '0;
            r_drop      <= 1'b0;
            case (r_state)
                StIdle: begin
                    if (|req_valid) begin
                        r_grant <= w_win;
                        r_state <= StLock;
                    end
                end
                StLock: begin
                    // A busy uart only stalls the issue; only a silent owner ages the lock.
                    if (w_owner_valid) begin
                        r_cnt <= '0;
                        if (!tx_busy) begin
                            r_tx_start  <= 1'b1;
                            r_tx_data   <= w_owner_data;
                            r_req_ready <= r_grant;
                            r_last      <= w_owner_last;
                            r_state     <= StIssue;
                        end
                    end else if (r_cnt == TO_LAST) begin
                        r_drop  <= 1'b1;
                        r_grant <= '0;
                        r_ptr   <= w_owner_idx;
                        r_cnt   <= '0;
                        r_state <= StIdle;
                    end else begin
                        r_cnt <= r_cnt + 1'b1;
                    end
                end
                StIssue: r_state <= StWaitHi;
                StWaitHi: begin
                    if (tx_busy) r_state <= StWaitLo;
                end
                StWaitLo: begin
                    if (!tx_busy) begin
                        if (r_last) begin
                            r_grant <= '0;
                            r_ptr   <= w_owner_idx;
                            r_state <= StIdle;
                        end else begin
                            r_state <= StLock;
                        end
                    end
                end
                default: r_state <= StIdle;
            endcase
        end
    end

    assign req_ready = r_req_ready;
    assign tx_data   = r_tx_data;
    assign tx_start  = r_tx_start;
    assign grant     = r_grant;
    assign drop      = r_drop;

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Bench for uart_tx_arbiter: queue-driven requesters, a simple uart busy model and
// a packet-level round-robin model checked against every issued byte.
module tb_uart_tx_arbiter;

    localparam int unsigned TO       = 20;
    localparam int          BUSY_CYC = 10;

    typedef struct packed {
        logic [1:0] idx;
        logic [7:0] data;
        logic       last;
    } exp_t;

    logic       clk;
    logic       rst_n;
    logic [2:0] req_valid;
    logic [7:0] req_data0, req_data1, req_data2;
    logic [2:0] req_last;
    logic [2:0] req_ready;
    logic [7:0] tx_data;
    logic       tx_start;
    logic       tx_busy;
    logic [2:0] grant;
    logic       drop;

    logic [8:0] q0[$], q1[$], q2[$];  // bit8 = last
    exp_t       exp_q[$];
    int         checks = 0;
    int         errors = 0;
    int         m_ptr  = 2;
    int         busy_cnt = 0;
    bit         force_busy = 0;
    bit         drop_ok = 0;
    bit         open_pkt = 0;
    int         open_idx = 0;
    logic [31:0] start_log = 0;

    uart_tx_arbiter #(.TIMEOUT_CYC(TO)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .req_valid (req_valid),
        .req_data0 (req_data0),
        .req_data1 (req_data1),
        .req_data2 (req_data2),
        .req_last  (req_last),
        .req_ready (req_ready),
        .tx_data   (tx_data),
        .tx_start  (tx_start),
        .tx_busy   (tx_busy),
        .grant     (grant),
        .drop      (drop)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] want);
        checks++;
        if (act !== want) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, want);
        end
    endtask

    function automatic exp_t mk(input int idx, input logic [7:0] d, input logic l);
        exp_t e;
        e.idx  = 2'(idx);
        e.data = d;
        e.last = l;
        return e;
    endfunction

    // Packet-level round robin over everything currently queued.
    task automatic load_model();
        logic [8:0] c0[$], c1[$], c2[$];
        logic [8:0] b;
        int p, i, n;
        bit found;
        c0 = q0; c1 = q1; c2 = q2;
        p = m_ptr;
        while (c0.size() + c1.size() + c2.size() > 0) begin
            found = 0;
            for (int k = 1; k <= 3; k++) begin
                i = (p + k) % 3;
                n = (i == 0) ? c0.size() : ((i == 1) ? c1.size() : c2.size());
                if (!found && n > 0) begin
                    found = 1;
                    p = i;
                    do begin
                        case (i)
                            0:       b = c0.pop_front();
                            1:       b = c1.pop_front();
                            default: b = c2.pop_front();
                        endcase
                        exp_q.push_back(mk(i, b[7:0], b[8]));
                        n = (i == 0) ? c0.size() : ((i == 1) ? c1.size() : c2.size());
                    end while (!b[8] && n > 0);
                end
            end
        end
        m_ptr = p;
    endtask

    function automatic logic [31:0] model_data();
        logic [31:0] v = 0;
        foreach (exp_q[j]) v = (v << 8) | 32'(exp_q[j].data);
        return v;
    endfunction

    function automatic logic [31:0] model_owners();
        logic [31:0] v = 0;
        foreach (exp_q[j]) v = (v << 2) | 32'(exp_q[j].idx);
        return v;
    endfunction

    task automatic push(input int idx, input logic [7:0] d, input logic l);
        case (idx)
            0:       q0.push_back({l, d});
            1:       q1.push_back({l, d});
            default: q2.push_back({l, d});
        endcase
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_drain(input string name);
        bit done = 0;
        for (int n = 0; n < 600; n++) begin
            tick();
            if (exp_q.size() == 0 && grant == 3'b000 && !tx_busy) begin
                done = 1;
                break;
            end
        end
        check({name, "_drain"}, 32'(done), 32'd1);
        check({name, "_queues_empty"}, 32'(q0.size() + q1.size() + q2.size()), 32'd0);
    endtask

    // Requesters and uart: inputs change only on the falling edge.
    initial begin
        req_valid = '0; req_last = '0;
        req_data0 = '0; req_data1 = '0; req_data2 = '0;
        tx_busy   = 1'b0;
        forever begin
            @(negedge clk);
            if (req_ready[0] && q0.size() > 0) void'(q0.pop_front());
            if (req_ready[1] && q1.size() > 0) void'(q1.pop_front());
            if (req_ready[2] && q2.size() > 0) void'(q2.pop_front());
            if (!rst_n)         busy_cnt = 0;
            else if (tx_start)  busy_cnt = BUSY_CYC;
            else if (busy_cnt > 0) busy_cnt--;
            tx_busy      = force_busy || (busy_cnt > 0);
            req_valid[0] = q0.size() > 0;
            req_valid[1] = q1.size() > 0;
            req_valid[2] = q2.size() > 0;
            req_data0    = (q0.size() > 0) ? q0[0][7:0] : 8'h00;
            req_data1    = (q1.size() > 0) ? q1[0][7:0] : 8'h00;
            req_data2    = (q2.size() > 0) ? q2[0][7:0] : 8'h00;
            req_last[0]  = (q0.size() > 0) ? q0[0][8] : 1'b0;
            req_last[1]  = (q1.size() > 0) ? q1[0][8] : 1'b0;
            req_last[2]  = (q2.size() > 0) ? q2[0][8] : 1'b0;
        end
    end

    // Compare process: every cycle out of reset.
    initial begin
        exp_t e;
        forever begin
            tick();
            if (rst_n) begin
                check("grant_onehot0", 32'($onehot0(grant)), 32'd1);
                if (drop) begin
                    check("drop_allowed", 32'(drop_ok), 32'd1);
                    open_pkt = 0;
                end
                if (tx_start) begin
                    check("start_while_busy", 32'(tx_busy), 32'd0);
                    start_log = {start_log[29:0], (grant[2] ? 2'd2 : (grant[1] ? 2'd1 : 2'd0))};
                    if (exp_q.size() == 0) begin
                        check("unexpected_start", 32'(tx_data), 32'hFFFF_FFFF);
                    end else begin
                        e = exp_q.pop_front();
                        check("byte_data", 32'(tx_data), 32'(e.data));
                        check("byte_owner", 32'(grant), 32'(3'b001 << e.idx));
                        check("ready_is_owner", 32'(req_ready), 32'(grant));
                        open_pkt = !e.last;
                        open_idx = int'(e.idx);
                    end
                end else begin
                    check("ready_without_start", 32'(req_ready), 32'd0);
                end
                if (open_pkt) check("lock_held", 32'(grant), 32'(3'b001 << open_idx));
            end
        end
    end

    initial begin
        #300000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1);
    end

    initial begin
        bit seen;
        int n_to;
        rst_n = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check("rst_grant", 32'(grant), 32'd0);
        check("rst_ready", 32'(req_ready), 32'd0);
        check("rst_start", 32'(tx_start), 32'd0);
        check("rst_drop", 32'(drop), 32'd0);
        check("rst_data", 32'(tx_data), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        tick();

        // Single byte: two-cycle latency, grant held until busy falls.
        exp_q.push_back(mk(0, 8'h41, 1'b1));
        push(0, 8'h41, 1'b1);
        tick();
        check("single_lock_grant", 32'(grant), 32'd1);
        check("single_not_yet", 32'(tx_start), 32'd0);
        tick();
        check("single_start", 32'(tx_start), 32'd1);
        check("single_data", 32'(tx_data), 32'h41);
        check("single_ready", 32'(req_ready), 32'd1);
        seen = 0;
        for (int n = 0; n < 40; n++) begin
            tick();
            if (!tx_busy) begin
                check("single_grant_clear", 32'(grant), 32'd0);
                seen = 1;
                break;
            end
            check("single_grant_hold", 32'(grant), 32'd1);
        end
        check("single_busy_fall", 32'(seen), 32'd1);
        m_ptr = 0;

        // Contention from reset: three 2-byte packets each, two rounds.
        rst_n = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        m_ptr = 2;
        tick();
        for (int r = 0; r < 4; r++) begin
            push(0, 8'hA0 + 8'(r), r[0]);
            push(1, 8'hB0 + 8'(r), r[0]);
            push(2, 8'hC0 + 8'(r), r[0]);
        end
        load_model();
        check("model_contention_order", model_owners(), 32'h0005_A05A);
        start_log = 0;
        wait_drain("contention");
        check("contention_order", start_log & 32'h00FF_FFFF, 32'h0005_A05A);

        // Lock hold: bit1 keeps the link for all three bytes while bit2 waits.
        push(1, 8'h31, 1'b0);
        push(1, 8'h32, 1'b0);
        push(1, 8'h33, 1'b1);
        push(2, 8'hE0, 1'b1);
        load_model();
        check("model_lock_bytes", model_data(), 32'h3132_33E0);
        start_log = 0;
        wait_drain("lock_hold");
        check("lock_hold_order", start_log & 32'hFF, 32'h56);

        // Timeout: bit0 goes silent mid-packet, bit1 is pending.
        drop_ok = 1;
        exp_q.push_back(mk(0, 8'h50, 1'b0));
        exp_q.push_back(mk(1, 8'h60, 1'b1));
        push(0, 8'h50, 1'b0);
        push(1, 8'h60, 1'b1);
        seen = 0;
        for (int n = 0; n < 10; n++) begin
            tick();
            if (tx_start) begin seen = 1; break; end
        end
        check("timeout_first_start", 32'(seen), 32'd1);
        for (int n = 0; n < 40; n++) begin
            tick();
            if (!tx_busy) break;
        end
        n_to = 0;
        for (int n = 1; n <= int'(TO) + 10; n++) begin
            tick();
            if (drop) begin n_to = n; break; end
        end
        check("timeout_cycles", 32'(n_to), 32'(TO));
        check("timeout_grant_clear", 32'(grant), 32'd0);
        tick();
        check("timeout_next_grant", 32'(grant), 32'b010);
        drop_ok = 0;
        wait_drain("timeout");
        m_ptr = 1;

        // Busy at entry: no start and no drop however long busy is held.
        force_busy = 1;
        exp_q.push_back(mk(2, 8'h70, 1'b0));
        push(2, 8'h70, 1'b0);
        push(2, 8'h71, 1'b1);
        for (int n = 0; n < int'(TO) + 5; n++) begin
            tick();
            check("busy_entry_no_start", 32'(tx_start), 32'd0);
        end
        check("busy_entry_grant", 32'(grant), 32'b100);
        force_busy = 0;
        tick();
        check("busy_release_start", 32'(tx_start), 32'd1);
        check("busy_release_data", 32'(tx_data), 32'h70);
        repeat (3) tick();
        check("mid_packet_grant", 32'(grant), 32'b100);

        // Asynchronous reset in the middle of the packet.
        #2;
        rst_n = 1'b0;
        exp_q.delete();
        open_pkt = 0;
        #1;
        check("async_rst_grant", 32'(grant), 32'd0);
        check("async_rst_ready", 32'(req_ready), 32'd0);
        check("async_rst_start", 32'(tx_start), 32'd0);
        check("async_rst_drop", 32'(drop), 32'd0);
        check("async_rst_data", 32'(tx_data), 32'd0);
        push(0, 8'h80, 1'b1);
        push(1, 8'h90, 1'b1);
        m_ptr = 2;
        load_model();
        check("model_post_reset", model_data(), 32'h0080_9071);
        start_log = 0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        wait_drain("post_reset");
        check("post_reset_order", start_log & 32'h3F, 32'h06);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
